// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU op sequencer.
// Holds state encoding, ALU function codes and the default queue depth.
package alu_op_sequencer_pkg;

    localparam int DEPTH_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [2:0] FN_ADD_RIPPLE = 3'b000;
    localparam logic [2:0] FN_ADD_CLA    = 3'b001;
    localparam logic [2:0] FN_SUB        = 3'b010;
    localparam logic [2:0] FN_AND        = 3'b011;
    localparam logic [2:0] FN_OR         = 3'b100;
    localparam logic [2:0] FN_XOR        = 3'b101;
    localparam logic [2:0] FN_SHL        = 3'b110;
    localparam logic [2:0] FN_HOLD       = 3'b111;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] func;
    } op_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Producer/control/result bundle of the ALU op sequencer.
// master drives ops and control, slave is the sequencer itself.
interface alu_op_sequencer_if
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          In_valid;
    logic          In_ready;
    logic [3:0]    In_data;
    logic [2:0]    In_func;
    logic          Start;
    logic          Abort;
    logic [3:0]    Data;
    logic [2:0]    Function;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Count;

    modport master (
        output In_valid, In_data, In_func, Start, Abort,
        input  In_ready, Data, Function, Busy, Done, Count
    );

    modport slave (
        input  In_valid, In_data, In_func, Start, Abort,
        output In_ready, Data, Function, Busy, Done, Count
    );

endinterface

// File: rtl/alu_op_sequencer_op_fifo.sv
// Op queue: power-of-two FIFO with wrapping pointers and occupancy count.
// Flush empties it in one edge and wins over push/pop.
module op_fifo
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  op_t           din,
    input  logic          pop,
    output op_t           dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_t           mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only entries below cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU ops while idle, then issues them one per cycle on Start.
// Outputs idle at FN_HOLD/0 so the downstream ALU register keeps its value.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                Clock,
    input  logic                Reset_b,
    alu_op_sequencer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [3:0]    data_q, data_d;
    logic [2:0]    func_q, func_d;
    logic          done_q, done_d;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    op_t           head;
    op_t           in_op;

    assign in_op       = '{data: bus.In_data, func: bus.In_func};
    assign bus.In_ready = (state_q == ST_IDLE) && !full;
    assign push        = bus.In_valid && bus.In_ready && !bus.Abort;

    op_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_b),
        .flush (bus.Abort),
        .push  (push),
        .din   (in_op),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        func_d  = func_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (bus.Abort) begin
            state_d = ST_IDLE;
            data_d  = '0;
            func_d  = FN_HOLD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    data_d = '0;
                    func_d = FN_HOLD;
                    // A push on the Start edge counts toward occupancy.
                    if (bus.Start)
                        state_d = (!empty || push) ? ST_RUN : ST_FINISH;
                end
                ST_RUN: begin
                    pop    = 1'b1;
                    data_d = head.data;
                    func_d = head.func;
                    if (count == CW'(1)) state_d = ST_FINISH;
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                    func_d  = FN_HOLD;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                    func_d  = FN_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            func_q  <= FN_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            func_q  <= func_d;
            done_q  <= done_d;
        end
    end

    assign bus.Data     = data_q;
    assign bus.Function = func_q;
    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.Done     = done_q;
    assign bus.Count    = count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a queue model.
// Model: ops issue in push order, one per cycle, then hold + one-cycle Done.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic Clock   = 1'b0;
    logic Reset_b = 1'b0;
    always #5 Clock = ~Clock;

    alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [6:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        bus.In_valid = 1'b0;
        bus.Start    = 1'b0;
        bus.Abort    = 1'b0;
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_data"}, 32'(bus.Data), 32'd0);
        chk({tag, "_func"}, 32'(bus.Function), 32'(3'b111));
    endtask

    task automatic push(input logic [3:0] d, input logic [2:0] f);
        bit acc;
        acc = (q.size() < DEPTH);
        chk("in_ready", 32'(bus.In_ready), 32'(acc));
        bus.In_valid = 1'b1;
        bus.In_data  = d;
        bus.In_func  = f;
        tick();
        idle_in();
        if (acc) q.push_back({d, f});
        chk("push_count", 32'(bus.Count), 32'(q.size()));
    endtask

    // Start (optionally with a same-edge push), then follow the issue order.
    task automatic run_seq(input bit wp, input logic [3:0] d,
                           input logic [2:0] f, input int abort_at);
        logic [6:0] e;
        int n;
        bus.Start = 1'b1;
        if (wp) begin
            bus.In_valid = 1'b1;
            bus.In_data  = d;
            bus.In_func  = f;
        end
        tick();
        idle_in();
        if (wp && q.size() < DEPTH) q.push_back({d, f});
        n = q.size();
        chk("start_busy", 32'(bus.Busy), 32'd1);
        chk("start_done", 32'(bus.Done), 32'd0);
        chk_hold("start");
        if (n == 0) begin
            tick();
            chk("empty_done", 32'(bus.Done), 32'd1);
            chk("empty_busy", 32'(bus.Busy), 32'd0);
            chk_hold("empty");
            tick();
            chk("empty_done_clr", 32'(bus.Done), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                bus.Abort = 1'b1;
                tick();
                idle_in();
                q.delete();
                chk_hold("abort");
                chk("abort_count", 32'(bus.Count), 32'd0);
                chk("abort_busy", 32'(bus.Busy), 32'd0);
                chk("abort_done", 32'(bus.Done), 32'd0);
                tick();
                chk("abort_done2", 32'(bus.Done), 32'd0);
                return;
            end
            tick();
            e = q.pop_front();
            chk("issue_data", 32'(bus.Data), 32'(e[6:3]));
            chk("issue_func", 32'(bus.Function), 32'(e[2:0]));
            chk("issue_count", 32'(bus.Count), 32'(q.size()));
            chk("issue_busy", 32'(bus.Busy), 32'd1);
            chk("issue_done", 32'(bus.Done), 32'd0);
        end
        tick();
        chk_hold("finish");
        chk("finish_done", 32'(bus.Done), 32'd1);
        chk("finish_busy", 32'(bus.Busy), 32'd0);
        tick();
        chk("done_clr", 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int n;
        int ab;
        idle_in();
        bus.In_data = '0;
        bus.In_func = '0;
        #12;
        chk_hold("reset");
        chk("reset_count", 32'(bus.Count), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        Reset_b = 1'b1;
        tick();

        push(4'd5, 3'b000);
        push(4'd3, 3'b001);
        push(4'd2, 3'b110);
        run_seq(1'b0, 4'd0, 3'd0, -1);

        for (int i = 0; i < 5; i++) push(4'(i + 8), 3'(i));
        chk("full_ready", 32'(bus.In_ready), 32'd0);
        chk("full_count", 32'(bus.Count), 32'(DEPTH));
        run_seq(1'b0, 4'd0, 3'd0, -1);

        run_seq(1'b0, 4'd0, 3'd0, -1);

        push(4'd1, 3'b010);
        push(4'd9, 3'b011);
        push(4'd6, 3'b100);
        run_seq(1'b0, 4'd0, 3'd0, 1);

        push(4'd4, 3'b101);
        push(4'd7, 3'b011);
        push(4'd8, 3'b001);
        bus.Start = 1'b1;
        tick();
        idle_in();
        tick();
        #2 Reset_b = 1'b0;
        #1;
        chk_hold("arst");
        chk("arst_count", 32'(bus.Count), 32'd0);
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        #1 Reset_b = 1'b1;
        q.delete();
        push(4'd12, 3'b010);
        run_seq(1'b0, 4'd0, 3'd0, -1);

        run_seq(1'b1, 4'd7, 3'b101, -1);

        repeat (25) begin
            n = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < n; i++)
                push(4'($urandom), 3'($urandom));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_seq(1'($urandom), 4'($urandom), 3'($urandom), ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning op-queue depth in entries (power of two, 2..16).
REQ-002 Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset_b  input  1  asynchronous, active-low reset.
REQ-004 In_valid  input  1  producer offers an op this cycle.
REQ-005 In_ready  output  1  queue can accept an op this cycle.
REQ-006 In_data  input  4  operand for the queued op.
REQ-007 In_func  input  3  ALU function code for the queued op.
REQ-008 Start  input  1  begin issuing all queued ops.
REQ-009 Abort  input  1  flush queue and stop issuing.
REQ-010 Data  output  4  registered operand driven to the downstream ALU register stage.
REQ-011 Function  output  3  registered function code driven to the downstream ALU register stage.
REQ-012 Busy  output  1  high while not IDLE.
REQ-013 Done  output  1  one-cycle pulse on sequence completion.
REQ-014 Count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN and FINISH.
REQ-016 A push SHALL occur on an edge where In_valid and In_ready are both high; In_ready SHALL equal (state==IDLE) and (Count<DEPTH).
REQ-017 The queue SHALL be FIFO with wrap-around read/write pointers; a push when full SHALL be impossible, since In_ready is low.
REQ-018 In IDLE, an edge with Start=1 and occupancy N>=1 SHALL move the FSM to RUN; N includes a push accepted on the same edge.
REQ-019 In IDLE, Start=1 with N=0, counting a same-edge push, SHALL move the FSM directly to FINISH, and no op SHALL be issued.
REQ-020 In RUN, each edge SHALL pop the head entry into Data/Function, so op i of N is visible after edge k+i, where k is the Start edge.
REQ-021 The edge that pops the last entry SHALL move the FSM to FINISH; Data/Function SHALL hold that last op during the FINISH cycle.
REQ-022 From FINISH, the next edge SHALL set Function=3'b111 (ALU hold), Data=0, Done=1 and the FSM to IDLE; Done SHALL clear on the following edge.
REQ-023 Whenever no op is being issued (IDLE, and after abort), Function SHALL be 3'b111 and Data SHALL be 4'b0, so the downstream register holds its value.
REQ-024 Start SHALL be ignored outside IDLE; In_valid SHALL be ignored outside IDLE.
REQ-025 Abort=1 on any edge SHALL empty the queue, force Function=3'b111 and Data=0, and set the FSM to IDLE without asserting Done; Abort SHALL take priority over Start and push.
REQ-026 Busy SHALL be high in RUN and FINISH and low in IDLE.
REQ-027 Count SHALL increment on a push, decrement on a pop, and SHALL never exceed DEPTH or underflow.

Reset
REQ-028 Reset_b=0 SHALL asynchronously set the FSM to IDLE, empty the queue (pointers=0, Count=0), Data=0, Function=3'b111 and Done=0.
REQ-029 Reset asserted mid-RUN SHALL discard all remaining ops; after release, the block SHALL accept pushes on the first edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the 3-bit function-code constants (FN_ADD_RIPPLE=000 ... FN_HOLD=111) and the default DEPTH.
REQ-031 Queue storage and pointers SHALL live in one sub-module, op_fifo (push/pop/full/empty/count); the FSM and output registers SHALL live in alu_op_sequencer.

Verification
REQ-032 Reset, push (5,000),(3,001),(2,110); then Start -> Data/Function = 5/000, 3/001, 2/110 on three consecutive cycles, FINISH, then Function=111 with Done=1 for exactly one cycle.
REQ-033 Push DEPTH=4 ops -> In_ready=0 and Count=4; a fifth In_valid is not accepted and Count stays 4.
REQ-034 Start with an empty queue -> no op issued, Function stays 111, Done pulses two edges after Start.
REQ-035 Push 3 ops, Start, Abort after the first op issues -> Function=111 next cycle, Count=0, Done never asserts, Busy=0.
REQ-036 Reset_b pulsed low mid-RUN (asynchronously, between edges) -> outputs immediately Data=0, Function=111, Count=0; a new push is accepted on the first edge after release.
REQ-037 In IDLE, push (7,101) on the same edge as Start with an empty queue -> FSM enters RUN, Data/Function=7/101 on the next cycle, then Done.
